// File: rtl/store_fwd_unit.sv
// Store-data forwarding for the EX->MEM boundary: resolves the store source register
// against the live writeback and a short history of recent writebacks.
module store_fwd_unit #(
    parameter int          DATA_W = 32,
    parameter int          REG_AW = 5,
    parameter int          DEPTH  = 3,
    parameter logic [5:0]  SW_OP  = 6'b101011
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [5:0]        ex_op,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [DATA_W-1:0] ex_rt_data,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [3:0]        mem_fwd_src,
    output logic              mem_fwd_valid,
    output logic [15:0]       fwd_count
);

    logic [DEPTH-1:0]  hist_valid_reg;
    logic [REG_AW-1:0] hist_rd_reg   [DEPTH];
    logic [DATA_W-1:0] hist_data_reg [DEPTH];
    logic [DEPTH-1:0]  hist_hit;

    logic [DATA_W-1:0] mem_data_reg;
    logic [3:0]        mem_src_reg;
    logic              mem_valid_reg;
    logic [15:0]       fwd_count_reg;

    logic              wb_commit;
    logic              req;
    logic              live_hit;
    logic [DATA_W-1:0] sel_data_next;
    logic [3:0]        sel_src_next;

    // Register 0 is never recorded, so a valid entry can never match ex_rt==0.
    assign wb_commit = wb_valid && (wb_rd != '0);
    assign req       = (ex_op == SW_OP) && (ex_rt != '0) && !flush;
    assign live_hit  = wb_commit && (wb_rd == ex_rt);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hist_hit[gi] = hist_valid_reg[gi] && (hist_rd_reg[gi] == ex_rt);
        end
    endgenerate

    // Oldest-to-newest scan so the newest match wins; the live write beats all history.
    always_comb begin
        sel_data_next = ex_rt_data;
        sel_src_next  = 4'd0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hist_hit[i]) begin
                sel_data_next = hist_data_reg[i];
                sel_src_next  = 4'(i + 2);
            end
        end
        if (live_hit) begin
            sel_data_next = wb_data;
            sel_src_next  = 4'd1;
        end
        if (!req) begin
            sel_data_next = ex_rt_data;
            sel_src_next  = 4'd0;
        end
    end

    // History shifts on every committed write, independent of stall/flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist_valid_reg <= '0;
        end else if (wb_commit) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                hist_valid_reg[i] <= hist_valid_reg[i-1];
                hist_rd_reg[i]    <= hist_rd_reg[i-1];
                hist_data_reg[i]  <= hist_data_reg[i-1];
            end
            hist_valid_reg[0] <= 1'b1;
            hist_rd_reg[0]    <= wb_rd;
            hist_data_reg[0]  <= wb_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_data_reg  <= '0;
            mem_src_reg   <= 4'd0;
            mem_valid_reg <= 1'b0;
            fwd_count_reg <= 16'd0;
        end else if (!stall) begin
            mem_data_reg  <= sel_data_next;
            mem_src_reg   <= sel_src_next;
            mem_valid_reg <= (sel_src_next != 4'd0);
            if ((sel_src_next != 4'd0) && (fwd_count_reg != 16'hFFFF)) begin
                fwd_count_reg <= fwd_count_reg + 16'd1;
            end
        end
    end

    assign mem_store_data = mem_data_reg;
    assign mem_fwd_src    = mem_src_reg;
    assign mem_fwd_valid  = mem_valid_reg;
    assign fwd_count      = fwd_count_reg;

endmodule

// File: doc/store_fwd_unit.md
STORE_FWD_UNIT -- requirements
Module: store_fwd_unit

Interface
REQ-001 Parameter DATA_W, 32, width of register data.
REQ-002 Parameter REG_AW, 5, register-address width.
REQ-003 Parameter DEPTH, 3, number of past writeback events retained (1..8).
REQ-004 Parameter SW_OP, 6'b101011, opcode identifying a store word.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 stall  input  1  hold MEM-stage outputs; EX request is not consumed.
REQ-008 flush  input  1  kill the EX-stage request this cycle.
REQ-009 ex_op  input  6  opcode of the instruction in EX.
REQ-010 ex_rt  input  REG_AW  store source register of the EX instruction.
REQ-011 ex_rt_data  input  DATA_W  register-file value read for ex_rt.
REQ-012 wb_valid  input  1  a register write is committing this cycle.
REQ-013 wb_rd  input  REG_AW  destination of the committing write.
REQ-014 wb_data  input  DATA_W  data of the committing write.
REQ-015 mem_store_data  output  DATA_W  resolved store data for the MEM stage.
REQ-016 mem_fwd_src  output  4  0 = register file, 1 = live writeback, 2+i = history entry i.
REQ-017 mem_fwd_valid  output  1  MEM stage holds a store whose data was forwarded.
REQ-018 fwd_count  output  16  saturating count of forwarded stores.

Function
REQ-019 The block SHALL keep DEPTH history entries {valid, rd, data}; entry 0 is the newest.
REQ-020 On a clock edge with wb_valid=1 and wb_rd!=0, entries SHALL shift (i -> i+1, entry DEPTH-1 discarded) and entry 0 SHALL load {1, wb_rd, wb_data}.
REQ-021 wb_valid=0 or wb_rd=0 SHALL leave the history unchanged; stall and flush SHALL NOT affect the history.
REQ-022 A request exists when ex_op==SW_OP, ex_rt!=0 and flush=0.
REQ-023 Source resolution priority: live writeback (wb_valid, wb_rd==ex_rt, wb_rd!=0) > history entry 0 > ... > entry DEPTH-1 > register file.
REQ-024 A history entry matches only when valid=1 and rd==ex_rt.
REQ-025 Latency: request in EX at edge N SHALL appear on mem_* outputs after edge N (one cycle, registered).
REQ-026 With stall=0 and a request, mem_store_data SHALL load the selected data and mem_fwd_src the selected code; mem_fwd_valid SHALL be 1 iff code!=0.
REQ-027 With stall=0 and no request (non-store, ex_rt=0, or flush=1), mem_store_data SHALL load ex_rt_data, mem_fwd_src 0, mem_fwd_valid 0.
REQ-028 With stall=1, mem_store_data, mem_fwd_src and mem_fwd_valid SHALL hold, regardless of flush.
REQ-029 fwd_count SHALL increment by 1 on each edge where stall=0 and a forwarded request (code!=0) is captured; it SHALL saturate at 16'hFFFF.
REQ-030 Live writeback and history shift in the same cycle: resolution SHALL use pre-shift history; the live write takes priority over its own future entry.
REQ-031 Duplicate rd in several entries: the newest matching entry SHALL win.
REQ-032 Register 0 SHALL never be forwarded nor recorded.

Reset
REQ-033 With reset=1 at an edge, all history valid bits, mem_store_data, mem_fwd_src, mem_fwd_valid and fwd_count SHALL become 0.
REQ-034 reset SHALL override stall, flush and wb_valid in the same cycle.
REQ-035 A request present during reset SHALL be dropped; the first request after reset deasserts SHALL resolve normally.

Verification
REQ-036 History hit: write r8=0x11111111, then SW rt=8 with ex_rt_data=0 -> next cycle mem_store_data=0x11111111, mem_fwd_src=2, fwd_count=1.
REQ-037 Priority: history r8=0xA, r8=0xB (newest), live wb r8=0xC with SW rt=8 -> src=1, data=0xC; without live wb -> src=2, data=0xB.
REQ-038 Eviction (DEPTH=3): write r5 then r6, r7, r9 -> SW rt=5 gives src=0, data=ex_rt_data.
REQ-039 Stall/flush: capture forwarded SW, then stall=1 with flush=1 for 3 cycles -> outputs held, fwd_count unchanged; release with flush=1 -> src=0, valid=0.
REQ-040 Register 0: wb r0=0xFFFF, SW rt=0 -> src=0, no history change, fwd_count unchanged.
REQ-041 Saturation/reset: 65536 forwarded stores -> fwd_count=0xFFFF held; reset=1 -> all outputs 0, subsequent SW rt=8 resolves from register file.
